// File: rtl/cdb_arbiter.sv
// Shared common-data-bus arbiter: per-producer result FIFOs feeding NUM_BUS registered
// broadcast buses, granted round-robin starting from rr_ptr.
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_BUS    = 2,
  parameter int DATA_W     = 32,
  parameter int ROB_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ROB_W-1:0]  src_robNum,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_BUS-1:0]        bus_iscast,
  output logic [NUM_BUS*ROB_W-1:0]  bus_robNum,
  output logic [NUM_BUS*DATA_W-1:0] bus_data,
  output logic [NUM_BUS*3-1:0]      bus_src
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Handshake: a result transfers on a rising edge where src_valid[i] && src_ready[i];
  // src_ready depends only on the registered count, never on same-cycle pops.

  logic [ROB_W-1:0]  tag_mem_q [NUM_SRC][FIFO_DEPTH];
  logic [ROB_W-1:0]  tag_mem_d [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] dat_mem_q [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] dat_mem_d [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_SRC];
  logic [CNT_W-1:0]  cnt_q [NUM_SRC];
  logic [CNT_W-1:0]  cnt_d [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0] push, pop, empty;
  logic [ROB_W-1:0]   head_tag [NUM_SRC];
  logic [DATA_W-1:0]  head_dat [NUM_SRC];
  logic [SRC_W-1:0]   pos [NUM_SRC];

  logic [NUM_BUS-1:0] gnt_vld;
  logic [SRC_W-1:0]   gnt_src [NUM_BUS];
  logic [ROB_W-1:0]   gnt_tag [NUM_BUS];
  logic [DATA_W-1:0]  gnt_dat [NUM_BUS];

  logic [NUM_BUS-1:0] iscast_q, iscast_d;
  logic [ROB_W-1:0]   btag_q [NUM_BUS];
  logic [ROB_W-1:0]   btag_d [NUM_BUS];
  logic [DATA_W-1:0]  bdat_q [NUM_BUS];
  logic [DATA_W-1:0]  bdat_d [NUM_BUS];
  logic [2:0]         bsrc_q [NUM_BUS];
  logic [2:0]         bsrc_d [NUM_BUS];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_head
    assign head_tag[s] = tag_mem_q[s][rd_ptr_q[s]];
    assign head_dat[s] = dat_mem_q[s][rd_ptr_q[s]];
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (cnt_q[i] != FULL_CNT);
      empty[i]     = (cnt_q[i] == '0);
      push[i]      = src_valid[i] && (cnt_q[i] != FULL_CNT);
    end
  end

  // Distance of each source from rr_ptr in scan order.
  always_comb begin : rotate
    int p;
    p = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      p = s + NUM_SRC - int'(rr_ptr_q);
      if (p >= NUM_SRC) p = p - NUM_SRC;
      pos[s] = SRC_W'(p);
    end
  end

  // A non-empty source wins bus k when exactly k non-empty sources precede it in scan order.
  always_comb begin : arbitrate
    int rank;
    int last_pos;
    rank     = 0;
    last_pos = -1;
    pop      = '0;
    gnt_vld  = '0;
    rr_ptr_d = rr_ptr_q;
    for (int b = 0; b < NUM_BUS; b++) begin
      gnt_src[b] = '0;
      gnt_tag[b] = '0;
      gnt_dat[b] = '0;
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      rank = 0;
      for (int t = 0; t < NUM_SRC; t++) begin
        if (!empty[t] && (pos[t] < pos[s])) rank++;
      end
      if (!empty[s] && (rank < NUM_BUS)) begin
        pop[s] = 1'b1;
        for (int b = 0; b < NUM_BUS; b++) begin
          if (rank == b) begin
            gnt_vld[b] = 1'b1;
            gnt_src[b] = SRC_W'(s);
            gnt_tag[b] = head_tag[s];
            gnt_dat[b] = head_dat[s];
          end
        end
        if (int'(pos[s]) > last_pos) begin
          last_pos = int'(pos[s]);
          rr_ptr_d = SRC_W'((s + 1) % NUM_SRC);
        end
      end
    end
    if (flush) begin
      pop      = '0;
      gnt_vld  = '0;
      rr_ptr_d = '0;
    end
  end

  always_comb begin
    tag_mem_d = tag_mem_q;
    dat_mem_d = dat_mem_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (push[i]) begin
          tag_mem_d[i][wr_ptr_q[i]] = src_robNum[i*ROB_W +: ROB_W];
          dat_mem_d[i][wr_ptr_q[i]] = src_data[i*DATA_W +: DATA_W];
          wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  // Ungranted buses drop iscast but keep their last payload.
  always_comb begin
    iscast_d = gnt_vld;
    for (int b = 0; b < NUM_BUS; b++) begin
      btag_d[b] = gnt_vld[b] ? gnt_tag[b] : btag_q[b];
      bdat_d[b] = gnt_vld[b] ? gnt_dat[b] : bdat_q[b];
      bsrc_d[b] = gnt_vld[b] ? 3'(gnt_src[b]) : bsrc_q[b];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          tag_mem_q[i][j] <= '0;
          dat_mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q <= '0;
      iscast_q <= '0;
      for (int b = 0; b < NUM_BUS; b++) begin
        btag_q[b] <= '0;
        bdat_q[b] <= '0;
        bsrc_q[b] <= '0;
      end
    end else begin
      tag_mem_q <= tag_mem_d;
      dat_mem_q <= dat_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      iscast_q  <= iscast_d;
      btag_q    <= btag_d;
      bdat_q    <= bdat_d;
      bsrc_q    <= bsrc_d;
    end
  end

  assign bus_iscast = iscast_q;
  for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
    assign bus_robNum[b*ROB_W +: ROB_W]   = btag_q[b];
    assign bus_data[b*DATA_W +: DATA_W]   = bdat_q[b];
    assign bus_src[b*3 +: 3]              = bsrc_q[b];
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the out-of-order core. It replaces the fixed one-producer-per-bus CDB instances with a shared pool of `NUM_BUS` result buses fed by `NUM_SRC` producers (adder RS, load unit, future multiplier/branch units). Each producer gets a small result FIFO. Buses are granted round-robin, so no producer starves. Bus outputs are registered and fan out to every reservation station and the reorder buffer. The ROB's `resetAll` drives `flush`.

## Interface
Parameters:
- `NUM_SRC`, 4: number of producing units (2..8).
- `NUM_BUS`, 2: number of broadcast buses (1..`NUM_SRC`).
- `DATA_W`, 32: result data width.
- `ROB_W`, 4: ROB index width.
- `FIFO_DEPTH`, 2: entries per source FIFO (power of two, ≥2).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash from ROB (mispredict/exception).
- `src_valid`  in  `NUM_SRC`  producer i offers a result.
- `src_ready`  out  `NUM_SRC`  producer i's FIFO can accept.
- `src_robNum`  in  `NUM_SRC*ROB_W`  ROB tag, source i in slice i.
- `src_data`  in  `NUM_SRC*DATA_W`  result value, source i in slice i.
- `bus_iscast`  out  `NUM_BUS`  bus b carries a valid broadcast this cycle.
- `bus_robNum`  out  `NUM_BUS*ROB_W`  tag on bus b.
- `bus_data`  out  `NUM_BUS*DATA_W`  value on bus b.
- `bus_src`  out  `NUM_BUS*3`  index of the source that won bus b (debug, ROB stats).

## Operation
- **Push.** A result is pushed into FIFO i on a rising edge where `src_valid[i] && src_ready[i]`.
- **Ready.** `src_ready[i] = (count[i] != FIFO_DEPTH)`. It is combinational from registered count only and does not depend on same-cycle pops.
- **Arbitration.** Arbitration is combinational over FIFO heads each cycle.
  - Scan sources in order `rr_ptr, rr_ptr+1, … (mod NUM_SRC)`.
  - The first non-empty FIFO wins bus 0, the next wins bus 1, and so on, up to `NUM_BUS` grants.
  - Each source receives at most one grant per cycle.
- **Pop.** Granted heads are popped at the edge. Their tag, data and source index are registered onto the corresponding bus.
- **Ungranted buses.** `bus_iscast[b]=0` next cycle. `bus_robNum`/`bus_data`/`bus_src` hold their previous values.
- **Pointer update.** `rr_ptr` becomes (index of last granted source + 1) mod `NUM_SRC`. It is unchanged when nothing is granted.
- **Simultaneous push and pop** on one FIFO: both occur and count is unchanged. This is legal even when full, but ready is still 0 when full, so the push cannot happen in that case.
- **Flush.** Flush takes priority over everything:
  - all FIFOs are emptied (pointers/counts to 0);
  - any push that cycle is dropped;
  - `bus_iscast` goes to 0 at that edge;
  - `rr_ptr` is set to 0.
- **Reset.** On `reset` low, asynchronously:
  - all counts, pointers and `rr_ptr` are set to 0;
  - `bus_iscast=0`, `bus_robNum=0`, `bus_data=0`, `bus_src=0`;
  - `src_ready` becomes all-ones once reset clears the counts.
- **Order guarantees.** Per-source order is preserved (FIFO). No ordering is guaranteed across sources.
- **Width rule.** `bus_src` is zero-extended to 3 bits.

## Timing
- Latency: a result accepted at edge E appears on a bus for exactly one cycle after edge E+1 at the earliest (no bypass around the FIFO).
- Throughput: up to `NUM_BUS` broadcasts per cycle, and ≤1 per source per cycle.
- A producer holding `src_valid` with `src_ready=0` must keep tag/data stable. The arbiter never accepts while not ready.
- Reset mid-operation: everything clears immediately, with no broadcast after reset deassertion until new pushes arrive (earliest 2 edges after release).
- Worst-case wait for a non-empty head: ⌈`NUM_SRC`/`NUM_BUS`⌉ cycles.

## Test plan
All scenarios use defaults (4 sources, 2 buses, depth 2).
- **Reset:** assert reset mid-traffic → all `bus_iscast=0`, outputs 0, `src_ready=4'b1111` after counts clear; first push after release broadcasts 2 edges later.
- **Single producer:** src 2 pushes (tag 5, data 0x1234) at edge E → `bus_iscast=2'b01`, `bus_robNum[0]=5`, `bus_data[0]=0x1234`, `bus_src[0]=2` for one cycle after E+1.
- **All four push same edge with `rr_ptr=0`:**
  - next cycle: buses carry src 0, 1;
  - cycle after: src 2, 3;
  - final `rr_ptr=0`.
- **Backpressure:** src 1 pushes 3 times while src 0 hogs nothing and buses are idle-granted → stalls never drop data. With a forced-full FIFO (depth 2, pushes every cycle while grant suppressed by 4 busy sources), `src_ready[1]=0` after 2 accepts and tags emerge in push order.
- **Fairness:** sources 0–3 continuously valid for 8 cycles → each wins exactly 4 broadcasts and no source waits more than 2 cycles.
- **Flush:** flush in the same cycle as a push on src 3 with 2 entries queued on src 0 → `bus_iscast=0` next cycle, the src 3 push is dropped, all `src_ready=1`, and no stale tag is ever broadcast afterwards.
